// File: rtl/lib_switch_onehot_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lib_switch_onehot_buffered: NxM one-hot crossbar with per-output FIFOs,   |
// | valid/ready flow control and all-or-none multicast.                       |
// | Optional: LIB_SWITCH_SEL_CHECK_EN adds multi-bit select error reporting.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lib_switch_onehot_buffered #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [N-1:0]     i_sel      [M],
  input  logic [WIDTH-1:0] i_data     [N],
  input  logic [N-1:0]     i_valid,
  output logic [N-1:0]     o_in_ready,
  output logic [WIDTH-1:0] o_data     [M],
  output logic [M-1:0]     o_valid,
`ifdef LIB_SWITCH_SEL_CHECK_EN
  output logic [M-1:0]     o_sel_err,
  output logic [15:0]      o_err_cnt,
`endif
  input  logic [M-1:0]     i_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [M-1:0]     sel_ok;
  logic [M-1:0]     multi;
  logic [M-1:0]     full;
  logic [M-1:0]     push;
  logic [N-1:0]     accept;
  logic [M-1:0]     tgt       [N];
  logic [WIDTH-1:0] push_data [M];

  always_comb begin
    for (int m = 0; m < M; m++) begin
      multi[m]  = (i_sel[m] & (i_sel[m] - N'(1))) != '0;
      sel_ok[m] = (i_sel[m] != '0) && !multi[m];
    end
  end

  always_comb begin
    for (int n = 0; n < N; n++) begin
      tgt[n] = '0;
      for (int m = 0; m < M; m++) begin
        tgt[n][m] = sel_ok[m] & i_sel[m][n];
      end
    end
  end

  // An input is ready only if every one of its targets has room, so multicast is all-or-none.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      o_in_ready[n] = ce && reset_n && (tgt[n] != '0) && ((tgt[n] & full) == '0);
    end
  end

  assign accept = i_valid & o_in_ready;

  always_comb begin
    for (int m = 0; m < M; m++) begin
      push[m]      = sel_ok[m] && ((i_sel[m] & accept) != '0);
      push_data[m] = '0;
      for (int n = 0; n < N; n++) begin
        if (i_sel[m][n]) push_data[m] = push_data[m] | i_data[n];
      end
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_out
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop;

    // A pop at count 0 is impossible, so push+pop on an empty FIFO simply fills it.
    assign pop     = ce && (cnt_q != '0) && i_ready[m];
    assign full[m] = (cnt_q == CW'(DEPTH));

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push[m]) begin
        mem_d[wr_ptr_q] = push_data[m];
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push[m], pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign o_valid[m] = (cnt_q != '0);
    assign o_data[m]  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

`ifdef LIB_SWITCH_SEL_CHECK_EN
  logic [M-1:0] sel_err_q, sel_err_d;
  logic [15:0]  err_cnt_q, err_cnt_d;
  logic [16:0]  err_sum;

  always_comb begin
    sel_err_d = {M{ce}} & multi;
    err_sum   = {1'b0, err_cnt_q};
    for (int m = 0; m < M; m++) begin
      err_sum = err_sum + 17'(sel_err_d[m]);
    end
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err_q <= '0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_sel_err = sel_err_q;
  assign o_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lib_switch_onehot_buffered.sv
`default_nettype none
// Directed self-checking bench for lib_switch_onehot_buffered (N=M=5, WIDTH=64, DEPTH=2).
module tb_lib_switch_onehot_buffered;
  localparam int N = 5;
  localparam int M = 5;
  localparam int W = 64;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ce;
  logic [N-1:0] i_sel   [M];
  logic [W-1:0] i_data  [N];
  logic [N-1:0] i_valid;
  logic [N-1:0] o_in_ready;
  logic [W-1:0] o_data  [M];
  logic [M-1:0] o_valid;
  logic [M-1:0] i_ready;
`ifdef LIB_SWITCH_SEL_CHECK_EN
  logic [M-1:0] o_sel_err;
  logic [15:0]  o_err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lib_switch_onehot_buffered #(.N(N), .M(M), .WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_sel      (i_sel),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
`ifdef LIB_SWITCH_SEL_CHECK_EN
    .o_sel_err  (o_sel_err),
    .o_err_cnt  (o_err_cnt),
`endif
    .i_ready    (i_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    i_valid = '0;
    i_ready = '0;
    for (int m = 0; m < M; m++) i_sel[m] = '0;
    for (int n = 0; n < N; n++) i_data[n] = '0;
    tick();
    tick();

    // Reset state: empty outputs, no readiness even with a legal select
    i_sel[2] = 5'b00001;
    settle();
    check("rst_valid", 64'(o_valid), 64'h0);
    check("rst_data2", o_data[2], 64'h0);
    check("rst_in_ready", 64'(o_in_ready), 64'h0);
    reset_n = 1'b1;

    // 1: single word through out2 from in0
    i_valid   = 5'b00001;
    i_data[0] = 64'hA5;
    i_ready[2] = 1'b1;
    settle();
    check("t1_in_ready", 64'(o_in_ready), 64'h01);
    tick();
    i_valid = '0;
    check("t1_valid", 64'(o_valid), 64'h04);
    check("t1_data", o_data[2], 64'hA5);
    tick();
    check("t1_drained", 64'(o_valid), 64'h0);
    check("t1_data_zero", o_data[2], 64'h0);
    i_sel[2] = '0;
    i_ready  = '0;

    // 2: out1 from in3, back-pressure after two words
    i_sel[1]  = 5'b01000;
    i_valid   = 5'b01000;
    i_data[3] = 64'd1;
    settle();
    check("t2_rdy1", 64'(o_in_ready[3]), 64'h1);
    tick();
    i_data[3] = 64'd2;
    settle();
    check("t2_rdy2", 64'(o_in_ready[3]), 64'h1);
    tick();
    i_data[3] = 64'd3;
    settle();
    check("t2_rdy3_full", 64'(o_in_ready[3]), 64'h0);
    tick();
    i_valid = '0;
    check("t2_head1", o_data[1], 64'd1);
    i_ready[1] = 1'b1;
    tick();
    check("t2_head2", o_data[1], 64'd2);
    tick();
    check("t2_empty", 64'(o_valid), 64'h0);
    i_ready  = '0;
    i_sel[1] = '0;

    // 3: multicast in1 -> out0+out4, out4 full blocks both
    i_sel[4]  = 5'b00010;
    i_valid   = 5'b00010;
    i_data[1] = 64'h11;
    tick();
    i_data[1] = 64'h22;
    tick();
    i_sel[0]  = 5'b00010;
    i_data[1] = 64'h33;
    settle();
    check("t3_blocked", 64'(o_in_ready[1]), 64'h0);
    tick();
    check("t3_out0_empty", 64'(o_valid[0]), 64'h0);
    check("t3_out4_head", o_data[4], 64'h11);
    i_ready[4] = 1'b1;
    settle();
    check("t3_full_with_pop", 64'(o_in_ready[1]), 64'h0);
    tick();
    check("t3_out4_head2", o_data[4], 64'h22);
    settle();
    check("t3_ready_after_drain", 64'(o_in_ready[1]), 64'h1);
    tick();
    i_valid = '0;
    i_ready = '0;
    check("t3_out0_data", o_data[0], 64'h33);
    check("t3_out4_data", o_data[4], 64'h33);
    check("t3_valid", 64'(o_valid), 64'h11);
    i_ready = '1;
    i_sel[0] = '0;
    i_sel[4] = '0;
    tick();
    check("t3_drained", 64'(o_valid), 64'h0);
    i_ready = '0;

    // 4: push+pop at count 1, then at count 0
    i_sel[2]  = 5'b00001;
    i_valid   = 5'b00001;
    i_data[0] = 64'h44;
    tick();
    i_data[0]  = 64'h55;
    i_ready[2] = 1'b1;
    tick();
    i_valid = '0;
    check("t4_cnt1_valid", 64'(o_valid[2]), 64'h1);
    check("t4_cnt1_head", o_data[2], 64'h55);
    tick();
    check("t4_cnt1_kept", 64'(o_valid[2]), 64'h0);
    i_valid   = 5'b00001;
    i_data[0] = 64'h66;
    tick();
    i_valid    = '0;
    i_ready[2] = 1'b0;
    check("t4_cnt0_valid", 64'(o_valid[2]), 64'h1);
    check("t4_cnt0_data", o_data[2], 64'h66);

    // 5: reset with two words queued on out2
    i_valid   = 5'b00001;
    i_data[0] = 64'h77;
    tick();
    check("t5_queued_head", o_data[2], 64'h66);
    reset_n   = 1'b0;
    i_data[0] = 64'h99;
    settle();
    check("t5_rst_in_ready", 64'(o_in_ready), 64'h0);
    tick();
    check("t5_rst_valid", 64'(o_valid), 64'h0);
    check("t5_rst_data", o_data[2], 64'h0);
    reset_n = 1'b1;
    i_valid = '0;
    tick();
    check("t5_post_valid", 64'(o_valid), 64'h0);
    i_valid   = 5'b00001;
    i_data[0] = 64'h88;
    tick();
    i_valid = '0;
    check("t5_new_head", o_data[2], 64'h88);
    i_ready[2] = 1'b1;
    tick();
    check("t5_new_drained", 64'(o_valid), 64'h0);
    i_ready  = '0;
    i_sel[2] = '0;

    // ce low freezes the FIFO and forces ready low
    i_sel[3]  = 5'b00100;
    i_valid   = 5'b00100;
    i_data[2] = 64'hC3;
    tick();
    i_valid    = '0;
    ce         = 1'b0;
    i_ready[3] = 1'b1;
    settle();
    check("ce_in_ready", 64'(o_in_ready), 64'h0);
    tick();
    check("ce_hold_valid", 64'(o_valid), 64'h08);
    check("ce_hold_data", o_data[3], 64'hC3);
    ce = 1'b1;
    tick();
    check("ce_resume_pop", 64'(o_valid), 64'h0);
    i_ready  = '0;
    i_sel[3] = '0;

`ifdef LIB_SWITCH_SEL_CHECK_EN
    // 6: two-bit select on out3 for two cycles
    i_sel[3] = 5'b01100;
    i_valid  = 5'b01100;
    settle();
    check("t6_no_ready", 64'(o_in_ready), 64'h0);
    tick();
    check("t6_err_c1", 64'(o_sel_err), 64'h08);
    tick();
    check("t6_err_c2", 64'(o_sel_err), 64'h08);
    i_sel[3] = '0;
    i_valid  = '0;
    tick();
    check("t6_err_clear", 64'(o_sel_err), 64'h0);
    check("t6_err_cnt", 64'(o_err_cnt), 64'd2);
    check("t6_no_push", 64'(o_valid), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
